demo_tick_ctrl: RTL and testbench

Parametrised demo-harness controller for DE0-class boards, running entirely in the single fastclk domain.
- Replaces the derived slow clock with a one-cycle clock-enable tick, so the processor core runs on fastclk gated by tick.
- Provides HOLD/RUN/STEP/FAST execution modes, synchronised and debounced switches, a step button, and a tick counter.
- Drives an N-digit hex seven-segment display.
- Sits between board I/O and the processor core in the demo top.

---
 rtl/demo_tick_ctrl_if.sv | 45 ++++
 rtl/demo_tick_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_demo_tick_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/demo_tick_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : demo_tick_ctrl_if
// Description : Board-side and core-side signal bundle for demo_tick_ctrl.
//               Breakpoint signals exist only when DEMO_BREAKPOINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface demo_tick_ctrl_if #(
  parameter int N_SW     = 10,
  parameter int N_DIGITS = 2,
  parameter int CNT_W    = 16
);
  logic [N_SW-1:0]       sw_in;
  logic                  step_btn;
  logic [1:0]            mode;
  logic                  tick;
  logic [N_SW-1:0]       sw_stable;
  logic [CNT_W-1:0]      cyc_count;
  logic [7*N_DIGITS-1:0] seg;
  logic [1:0]            run_state;
`ifdef DEMO_BREAKPOINT_EN
  logic [CNT_W-1:0]      brk_value;
  logic                  brk_arm;
  logic                  brk_hit;

  modport master (
    output sw_in, step_btn, mode, brk_value, brk_arm,
    input  tick, sw_stable, cyc_count, seg, run_state, brk_hit
  );
  modport slave (
    input  sw_in, step_btn, mode, brk_value, brk_arm,
    output tick, sw_stable, cyc_count, seg, run_state, brk_hit
  );
`else
  modport master (
    output sw_in, step_btn, mode,
    input  tick, sw_stable, cyc_count, seg, run_state
  );
  modport slave (
    input  sw_in, step_btn, mode,
    output tick, sw_stable, cyc_count, seg, run_state
  );
`endif
endinterface
`default_nettype wire

// File: rtl/demo_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demo_tick_ctrl
// Description : Single-clock demo-harness controller: debounced inputs, a
//               HOLD/RUN/STEP/FAST clock-enable tick, tick counter and hex
//               seven-segment display. Optional macro: DEMO_BREAKPOINT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demo_tick_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int N_SW       = 10,
  parameter int DEB_CYCLES = 500000,
  parameter int N_DIGITS   = 2,
  parameter int CNT_W      = 16
) (
  input  logic            fastclk,
  input  logic            reset,
  demo_tick_ctrl_if.slave bus
);

  localparam int c_DIV      = CLK_HZ / TICK_HZ;
  localparam int c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_STEP_IDX = N_SW;
  localparam int c_MODE_IDX = N_SW + 1;
`ifdef DEMO_BREAKPOINT_EN
  localparam int c_ARM_IDX  = N_SW + 3;
  localparam int c_N_RAW    = N_SW + 4;
`else
  localparam int c_N_RAW    = N_SW + 3;
`endif
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

  generate
    if (c_DIV < 2 || DEB_CYCLES < 1 || N_DIGITS < 1 || N_DIGITS > 8 ||
        CNT_W < 4 * N_DIGITS) begin : g_param_check
      $error("demo_tick_ctrl: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_FAST = 2'b11
  } state_t;

  logic [c_N_RAW-1:0]              w_raw;
  logic [c_N_RAW-1:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [c_N_RAW-1:0]              deb_q, deb_d;
  logic [c_N_RAW-1:0][c_DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]                      w_mode_deb;
  logic                            w_step_deb;
  logic                            w_mode_chg;
  logic                            w_tick;
  logic                            w_tick_block;
  state_t                          state_q, state_d;
  logic [c_DIV_W-1:0]              div_q, div_d;
  logic                            tick_q, tick_d;
  logic                            step_prev_q, step_prev_d;
  logic [CNT_W-1:0]                cyc_q, cyc_d;
  logic [7*N_DIGITS-1:0]           w_seg;

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

`ifdef DEMO_BREAKPOINT_EN
  assign w_raw = {bus.brk_arm, bus.mode, bus.step_btn, bus.sw_in};
`else
  assign w_raw = {bus.mode, bus.step_btn, bus.sw_in};
`endif

  assign w_mode_deb = deb_q[c_MODE_IDX +: 2];
  assign w_step_deb = deb_q[c_STEP_IDX];

  always_comb begin
    sync1_d = w_raw;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: the counter only survives while synced and debounced disagree.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < c_N_RAW; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == c_DEB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef DEMO_BREAKPOINT_EN
  logic w_arm;
  logic w_brk_match;
  logic brk_q, brk_d;

  assign w_arm        = deb_q[c_ARM_IDX];
  assign w_brk_match  = w_arm && (state_q == ST_RUN || state_q == ST_FAST) &&
                        (cyc_q == bus.brk_value);
  // The gate on the output catches a tick already registered when the match appears.
  assign w_tick_block = brk_q | w_brk_match;
  assign w_tick       = tick_q & ~w_tick_block;

  always_comb begin
    brk_d = brk_q | w_brk_match;
    if (w_mode_chg || !w_arm) begin
      brk_d = 1'b0;
    end
  end

  assign bus.brk_hit   = brk_q;
  assign bus.run_state = brk_q ? ST_HOLD : state_q;
`else
  assign w_tick_block  = 1'b0;
  assign w_tick        = tick_q;
  assign bus.run_state = state_q;
`endif

  always_comb begin
    state_d     = state_t'(w_mode_deb);
    w_mode_chg  = (state_d != state_q);
    div_d       = '0;
    tick_d      = 1'b0;
    step_prev_d = w_step_deb;
    cyc_d       = cyc_q + {{(CNT_W-1){1'b0}}, w_tick};
    // A pending tick (including a step edge) is dropped when the mode changes.
    if (!w_mode_chg) begin
      case (state_q)
        ST_RUN: begin
          if (div_q == c_DIV_LAST) begin
            tick_d = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_STEP: tick_d = w_step_deb & ~step_prev_q;
        ST_FAST: tick_d = 1'b1;
        default: tick_d = 1'b0;
      endcase
    end
    if (w_tick_block) begin
      tick_d = 1'b0;
    end
  end

  always_comb begin
    w_seg = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_seg[7*k +: 7] = f_hex7(cyc_q[4*k +: 4]);
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_cnt_q   <= '0;
      state_q     <= ST_HOLD;
      div_q       <= '0;
      tick_q      <= 1'b0;
      step_prev_q <= 1'b0;
      cyc_q       <= '0;
`ifdef DEMO_BREAKPOINT_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      step_prev_q <= step_prev_d;
      cyc_q       <= cyc_d;
`ifdef DEMO_BREAKPOINT_EN
      brk_q       <= brk_d;
`endif
    end
  end

  assign bus.tick      = w_tick;
  assign bus.sw_stable = deb_q[N_SW-1:0];
  assign bus.cyc_count = cyc_q;
  assign bus.seg       = w_seg;

endmodule
`default_nettype wire

// File: tb/tb_demo_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_tick_ctrl
// Description : Self-checking bench for demo_tick_ctrl (DIV=10, DEB_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_tick_ctrl;
  localparam int N_SW     = 10;
  localparam int N_DIGITS = 2;
  localparam int CNT_W    = 8;
  localparam int DEB      = 4;
  localparam int DIV      = 10;

  logic fastclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int kmax, n, kr, exp_cnt, bv, r, total, npress, g, h;
  logic exp_tick;
  logic [N_SW-1:0] mask;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  demo_tick_ctrl_if #(.N_SW(N_SW), .N_DIGITS(N_DIGITS), .CNT_W(CNT_W)) bus ();

  demo_tick_ctrl #(
    .CLK_HZ(100), .TICK_HZ(10), .N_SW(N_SW), .DEB_CYCLES(DEB),
    .N_DIGITS(N_DIGITS), .CNT_W(CNT_W)
  ) dut (
    .fastclk(fastclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 fastclk = ~fastclk;

  function automatic logic [7*N_DIGITS-1:0] seg_of(input int v);
    logic [7*N_DIGITS-1:0] s;
    for (int d = 0; d < N_DIGITS; d++) s[7*d +: 7] = hex_tab[(v >> (4*d)) & 15];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge fastclk);
    @(negedge fastclk);
  endtask

  task automatic do_reset();
    bus.mode     = 2'b00;
    bus.step_btn = 1'b0;
    bus.sw_in    = '0;
`ifdef DEMO_BREAKPOINT_EN
    bus.brk_arm   = 1'b0;
    bus.brk_value = '0;
`endif
    reset = 1'b1;
    repeat (3) cyc1();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values, with garbage on the raw inputs while reset is held
    reset = 1'b1;
    bus.sw_in = N_SW'($urandom); bus.step_btn = 1'b1; bus.mode = 2'b11;
`ifdef DEMO_BREAKPOINT_EN
    bus.brk_arm = 1'b1; bus.brk_value = '0;
`endif
    repeat (4) cyc1();
    do_reset();
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_sw", 32'(bus.sw_stable), 32'd0);
    chk("rst_cnt", 32'(bus.cyc_count), 32'd0);
    chk("rst_seg", 32'(bus.seg), 32'(seg_of(0)));
    chk("rst_state", 32'(bus.run_state), 32'd0);
`ifdef DEMO_BREAKPOINT_EN
    chk("rst_brk", 32'(bus.brk_hit), 32'd0);
`endif

    // RUN: state after 7 cycles, first tick 10 cycles later, then every DIV
    do_reset();
    bus.mode = 2'b01;
    exp_cnt = 0;
    kmax = 40 + $urandom_range(0, 25);
    for (int k = 1; k <= kmax; k++) begin
      cyc1();
      exp_tick = (k >= 17) && (((k - 17) % DIV) == 0);
      chk("run_state", 32'(bus.run_state), (k >= 7) ? 32'd1 : 32'd0);
      chk("run_tick", 32'(bus.tick), 32'(exp_tick));
      chk("run_cnt", 32'(bus.cyc_count), 32'(exp_cnt));
      chk("run_seg", 32'(bus.seg), 32'(seg_of(exp_cnt)));
      if (k == 38) chk("run_seg_03", 32'(bus.seg), 32'(14'b1000000_0110000));
      if (exp_tick) exp_cnt++;
    end

    // Reset on the cycle a RUN tick is about to be issued
    do_reset();
    bus.mode = 2'b01;
    n  = $urandom_range(0, 2);
    kr = 16 + DIV * n;
    repeat (kr) cyc1();
    chk("pre_rst_tick", 32'(bus.tick), 32'd0);
    chk("pre_rst_cnt", 32'(bus.cyc_count), 32'(n));
    reset = 1'b1;
    bus.mode = 2'b00;
    cyc1();
    reset = 1'b0;
    chk("mid_rst_tick", 32'(bus.tick), 32'd0);
    chk("mid_rst_cnt", 32'(bus.cyc_count), 32'd0);
    chk("mid_rst_state", 32'(bus.run_state), 32'd0);

    // STEP: short glitches give nothing, each held press gives one tick
    do_reset();
    bus.mode = 2'b10;
    repeat (8) cyc1();
    chk("step_state", 32'(bus.run_state), 32'd2);
    exp_cnt = 0;
    npress = $urandom_range(2, 3);
    for (int p = 0; p < npress; p++) begin
      g = $urandom_range(1, 3);
      bus.step_btn = 1'b1;
      repeat (g) begin cyc1(); chk("glitch_tick", 32'(bus.tick), 32'd0); end
      bus.step_btn = 1'b0;
      repeat (8) begin cyc1(); chk("glitch_tick", 32'(bus.tick), 32'd0); end
      h = $urandom_range(12, 30);
      bus.step_btn = 1'b1;
      for (int k = 1; k <= h; k++) begin
        cyc1();
        chk("step_tick", 32'(bus.tick), (k == 7) ? 32'd1 : 32'd0);
        chk("step_cnt", 32'(bus.cyc_count), 32'(exp_cnt + ((k >= 8) ? 1 : 0)));
      end
      exp_cnt++;
      bus.step_btn = 1'b0;
      repeat (10) begin cyc1(); chk("release_tick", 32'(bus.tick), 32'd0); end
    end
    chk("step_total", 32'(bus.cyc_count), 32'(npress));

    // FAST: tick every cycle, counter wraps through 255 -> 0
    do_reset();
    bus.mode = 2'b11;
    for (int k = 1; k <= 300; k++) begin
      cyc1();
      exp_cnt = (k >= 8) ? ((k - 8) % 256) : 0;
      chk("fast_state", 32'(bus.run_state), (k >= 7) ? 32'd3 : 32'd0);
      chk("fast_tick", 32'(bus.tick), (k >= 8) ? 32'd1 : 32'd0);
      chk("fast_cnt", 32'(bus.cyc_count), 32'(exp_cnt));
      chk("fast_seg", 32'(bus.seg), 32'(seg_of(exp_cnt)));
      if (k == 264) chk("fast_seg_00", 32'(bus.seg), 32'(14'b1000000_1000000));
    end

    // Switch debounce: bursts of short runs are rejected, a steady change lands at +6
    do_reset();
    mask = N_SW'($urandom_range(1, (1 << N_SW) - 1)) | N_SW'(10'h008);
    total = 0;
    while (total < 20) begin
      bus.sw_in = mask;
      r = $urandom_range(1, 3);
      repeat (r) begin cyc1(); chk("burst_sw", 32'(bus.sw_stable), 32'd0); end
      total += r;
      bus.sw_in = '0;
      r = $urandom_range(1, 3);
      repeat (r) begin cyc1(); chk("burst_sw", 32'(bus.sw_stable), 32'd0); end
      total += r;
    end
    bus.sw_in = mask;
    for (int k = 1; k <= 10; k++) begin
      cyc1();
      chk("settle_sw", 32'(bus.sw_stable), (k >= 6) ? 32'(mask) : 32'd0);
    end

`ifdef DEMO_BREAKPOINT_EN
    // Breakpoint in FAST, cleared by moving to STEP, then a single step
    do_reset();
    bv = $urandom_range(3, 20);
    bus.brk_value = CNT_W'(bv);
    bus.brk_arm   = 1'b1;
    bus.mode      = 2'b11;
    for (int k = 1; k <= bv + 20; k++) begin
      cyc1();
      chk("brk_cnt", 32'(bus.cyc_count), (k >= 8) ? 32'(((k - 8) < bv) ? (k - 8) : bv) : 32'd0);
      chk("brk_tick", 32'(bus.tick), ((k >= 8) && ((k - 8) < bv)) ? 32'd1 : 32'd0);
      chk("brk_hit", 32'(bus.brk_hit), (k >= 9 + bv) ? 32'd1 : 32'd0);
      chk("brk_state", 32'(bus.run_state), ((k >= 7) && (k < 9 + bv)) ? 32'd3 : 32'd0);
    end
    bus.mode = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      cyc1();
      chk("brk_clr_tick", 32'(bus.tick), 32'd0);
      chk("brk_clr_hit", 32'(bus.brk_hit), (k < 7) ? 32'd1 : 32'd0);
      chk("brk_clr_state", 32'(bus.run_state), (k >= 7) ? 32'd2 : 32'd0);
    end
    bus.step_btn = 1'b1;
    repeat (12) cyc1();
    bus.step_btn = 1'b0;
    repeat (8) cyc1();
    chk("brk_step_cnt", 32'(bus.cyc_count), 32'(bv + 1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
